parity_sched: RTL and testbench

Round-robin scheduler that shares one byte-wide parity engine (XOR-reduce of 8 bits) among several requesters. It grants one requester at a time, latches that requester's multi-byte word, and feeds the word through the engine one byte per cycle while accumulating the result. It returns a single parity bit tagged with the requester index. It sits between the per-channel framing logic and the shared parity datapath.

---
 rtl/parity_sched_if.sv | 25 ++
 rtl/parity_sched.sv | 114 +++++++++++
 tb/tb_parity_sched.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/parity_sched_if.sv
// rtl/parity_sched_if.sv - request/result bundle between framing channels and the shared parity scheduler
interface parity_sched_if #(
  parameter int N_REQ = 4,
  parameter int BYTES = 4
);
  localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]         req;
  logic [N_REQ*8*BYTES-1:0] data_in;
  logic [N_REQ-1:0]         gnt;
  logic                     busy;
  logic                     done;
  logic [IDW-1:0]           done_id;
  logic                     parity_out;

  modport master (
    output req, data_in,
    input  gnt, busy, done, done_id, parity_out
  );

  modport slave (
    input  req, data_in,
    output gnt, busy, done, done_id, parity_out
  );
endinterface

// File: rtl/parity_sched.sv
// rtl/parity_sched.sv - round-robin arbiter feeding one byte-wide parity engine
module parity_sched #(
  parameter int N_REQ = 4,
  parameter int BYTES = 4,
  parameter int ODD   = 0
) (
  input logic          clk,
  input logic          rst_n,
  parity_sched_if.slave bus
);
  localparam int   W       = 8 * BYTES;
  localparam int   IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int   CW      = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic ODD_BIT = (ODD != 0);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   id;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     shreg;
  logic             acc;

  logic             found;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;
  logic [IDW-1:0]   ptr_next;
  logic [W-1:0]     win_word;
  logic [N_REQ-1:0] win_onehot;
  logic             acc_next;
  int               j;

  // First requester at or above ptr, wrapping; ptr itself gets top priority.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = IDW'(j);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    win_word   = '0;
    win_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        win_word      = bus.data_in[i*W +: W];
        win_onehot[i] = 1'b1;
      end
    end
  end

  assign ptr_next = (win == IDW'(N_REQ - 1)) ? '0 : win + 1'b1;
  assign acc_next = acc ^ (^shreg[7:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      ptr            <= '0;
      id             <= '0;
      cnt            <= '0;
      shreg          <= '0;
      acc            <= 1'b0;
      bus.gnt        <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.done_id    <= '0;
      bus.parity_out <= 1'b0;
    end else begin
      bus.gnt  <= '0;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state    <= CALC;
            shreg    <= win_word;
            acc      <= 1'b0;
            cnt      <= '0;
            id       <= win;
            ptr      <= ptr_next;
            bus.gnt  <= win_onehot;
            bus.busy <= 1'b1;
          end
        end
        CALC: begin
          acc   <= acc_next;
          shreg <= shreg >> 8;
          cnt   <= cnt + 1'b1;
          // Result is registered on the last byte so done lines up with the DONE state.
          if (cnt == CW'(BYTES - 1)) begin
            state          <= DONE;
            bus.done       <= 1'b1;
            bus.parity_out <= acc_next ^ ODD_BIT;
            bus.done_id    <= id;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_parity_sched.sv
// tb/tb_parity_sched.sv - directed self-checking bench for parity_sched
module tb_parity_sched;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  parity_sched_if #(.N_REQ(4), .BYTES(4)) if0 ();
  parity_sched_if #(.N_REQ(4), .BYTES(4)) if1 ();

  parity_sched #(.N_REQ(4), .BYTES(4), .ODD(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  parity_sched #(.N_REQ(4), .BYTES(4), .ODD(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic set_req(input bit sel, input logic [3:0] r);
    if (sel) if1.req = r; else if0.req = r;
  endtask

  task automatic set_word(input bit sel, input int id, input logic [31:0] w);
    if (sel) if1.data_in[id*32 +: 32] = w; else if0.data_in[id*32 +: 32] = w;
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Single-requester transaction; returns grant at T+1, result and gnt-to-done distance.
  task automatic issue(input bit sel, input int id, input logic [31:0] w,
                       output logic [3:0] g, output logic p, output logic [1:0] did,
                       output int lat);
    @(negedge clk);
    set_word(sel, id, w);
    set_req(sel, 4'(1 << id));
    @(negedge clk);
    g = sel ? if1.gnt : if0.gnt;
    set_req(sel, 4'b0);
    lat = -1;
    p   = 1'bx;
    did = 2'bxx;
    for (int k = 1; k <= 10; k++) begin
      if ((sel ? if1.done : if0.done) === 1'b1) begin
        lat = k;
        p   = sel ? if1.parity_out : if0.parity_out;
        did = sel ? if1.done_id : if0.done_id;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    if0.req = '0; if0.data_in = '0;
    if1.req = '0; if1.data_in = '0;
    repeat (3) @(negedge clk);
    n_total++; if (if0.gnt !== 4'b0) $display("FAIL reset_gnt: got %b want 0000", if0.gnt); else n_pass++;
    n_total++; if (if0.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", if0.busy); else n_pass++;
    n_total++; if (if0.done !== 1'b0) $display("FAIL reset_done: got %b want 0", if0.done); else n_pass++;
    n_total++; if (if0.done_id !== 2'd0) $display("FAIL reset_done_id: got %0d want 0", if0.done_id); else n_pass++;
    n_total++; if (if0.parity_out !== 1'b0) $display("FAIL reset_parity: got %b want 0", if0.parity_out); else n_pass++;
    n_total++; if (if1.busy !== 1'b0) $display("FAIL reset_busy_odd: got %b want 0", if1.busy); else n_pass++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (if0.busy !== 1'b0) $display("FAIL idle_no_req_busy: got %b want 0", if0.busy); else n_pass++;
  endtask

  task automatic test_single();
    bit early;
    early = 1'b0;
    set_word(0, 2, 32'h0000_00FF);
    if0.req = 4'b0100;
    @(negedge clk);
    n_total++; if (if0.gnt !== 4'b0100) $display("FAIL single_gnt: got %b want 0100", if0.gnt); else n_pass++;
    n_total++; if (if0.busy !== 1'b1) $display("FAIL single_busy: got %b want 1", if0.busy); else n_pass++;
    if0.req = 4'b0;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      if (k == 2) begin
        n_total++; if (if0.gnt !== 4'b0) $display("FAIL single_gnt_pulse: got %b want 0000", if0.gnt); else n_pass++;
      end
      if (k < 5 && if0.done !== 1'b0) early = 1'b1;
    end
    n_total++; if (early) $display("FAIL single_early_done: got 1 want 0"); else n_pass++;
    n_total++; if (if0.done !== 1'b1) $display("FAIL single_done: got %b want 1", if0.done); else n_pass++;
    n_total++; if (if0.parity_out !== 1'b0) $display("FAIL single_parity: got %b want 0", if0.parity_out); else n_pass++;
    n_total++; if (if0.done_id !== 2'd2) $display("FAIL single_done_id: got %0d want 2", if0.done_id); else n_pass++;
    @(negedge clk);
    n_total++; if (if0.done !== 1'b0) $display("FAIL single_done_fall: got %b want 0", if0.done); else n_pass++;
    n_total++; if (if0.busy !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", if0.busy); else n_pass++;
    n_total++; if (if0.done_id !== 2'd2) $display("FAIL single_id_hold: got %0d want 2", if0.done_id); else n_pass++;
  endtask

  task automatic test_parity_words();
    logic [3:0] g; logic p; logic [1:0] did; int lat;
    issue(0, 1, 32'h8000_0001, g, p, did, lat);
    n_total++; if (g !== 4'b0010) $display("FAIL even_a_gnt: got %b want 0010", g); else n_pass++;
    n_total++; if (p !== 1'b0) $display("FAIL even_a_parity: got %b want 0", p); else n_pass++;
    n_total++; if (did !== 2'd1) $display("FAIL even_a_id: got %0d want 1", did); else n_pass++;
    n_total++; if (lat != 5) $display("FAIL even_a_latency: got %0d want 5", lat); else n_pass++;
    issue(0, 3, 32'h0001_0000, g, p, did, lat);
    n_total++; if (p !== 1'b1) $display("FAIL even_b_parity: got %b want 1", p); else n_pass++;
    n_total++; if (did !== 2'd3) $display("FAIL even_b_id: got %0d want 3", did); else n_pass++;
    issue(1, 1, 32'h8000_0001, g, p, did, lat);
    n_total++; if (p !== 1'b1) $display("FAIL odd_a_parity: got %b want 1", p); else n_pass++;
    n_total++; if (lat != 5) $display("FAIL odd_a_latency: got %0d want 5", lat); else n_pass++;
    issue(1, 3, 32'h0001_0000, g, p, did, lat);
    n_total++; if (p !== 1'b0) $display("FAIL odd_b_parity: got %b want 1->0", p); else n_pass++;
    n_total++; if (did !== 2'd3) $display("FAIL odd_b_id: got %0d want 3", did); else n_pass++;
  endtask

  task automatic test_fairness();
    int gid[8]; int gcyc[8]; int dids[8];
    int ng; int nd; int overlap;
    int exp_ids[6];
    exp_ids = '{0, 1, 2, 3, 0, 1};
    ng = 0; nd = 0; overlap = 0;
    reset_pulse();
    for (int i = 0; i < 4; i++) set_word(0, i, 32'(i + 1));
    @(negedge clk);
    if0.req = 4'b1111;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (if0.gnt !== 4'b0 && if0.done === 1'b1) overlap++;
      if (if0.gnt !== 4'b0 && ng < 8) begin
        gcyc[ng] = c;
        gid[ng] = (if0.gnt == 4'b0001) ? 0 : (if0.gnt == 4'b0010) ? 1 :
                  (if0.gnt == 4'b0100) ? 2 : (if0.gnt == 4'b1000) ? 3 : -1;
        ng++;
      end
      if (if0.done === 1'b1 && nd < 8) begin
        dids[nd] = int'(if0.done_id);
        nd++;
      end
    end
    if0.req = 4'b0;
    n_total++; if (ng != 6) $display("FAIL fair_grant_count: got %0d want 6", ng); else n_pass++;
    n_total++; if (nd != 6) $display("FAIL fair_done_count: got %0d want 6", nd); else n_pass++;
    n_total++; if (overlap != 0) $display("FAIL fair_gnt_done_overlap: got %0d want 0", overlap); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      if (i < ng) begin
        n_total++; if (gid[i] != exp_ids[i]) $display("FAIL fair_order_%0d: got %0d want %0d", i, gid[i], exp_ids[i]); else n_pass++;
      end
      if (i > 0 && i < ng) begin
        n_total++; if (gcyc[i] - gcyc[i-1] != 6) $display("FAIL fair_spacing_%0d: got %0d want 6", i, gcyc[i] - gcyc[i-1]); else n_pass++;
      end
      if (i < nd && i < ng) begin
        n_total++; if (dids[i] != gid[i]) $display("FAIL fair_done_id_%0d: got %0d want %0d", i, dids[i], gid[i]); else n_pass++;
      end
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_rotation();
    logic [3:0] g; logic p; logic [1:0] did; int lat;
    logic [3:0] gseq[4]; int ng; bit saw1; logic busy_at_pulse;
    ng = 0; saw1 = 1'b0; busy_at_pulse = 1'b0;
    reset_pulse();
    issue(0, 0, 32'h0000_0001, g, p, did, lat);
    if0.req = 4'b1001;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (if0.gnt !== 4'b0) begin
        if (ng < 4) gseq[ng] = if0.gnt;
        ng++;
        if (if0.gnt[1] === 1'b1) saw1 = 1'b1;
      end
      if (c == 3) begin
        busy_at_pulse = if0.busy;
        if0.req = 4'b1011;
      end
      if (c == 4) if0.req = 4'b1001;
      if (c == 8) if0.req = 4'b0000;
    end
    n_total++; if (busy_at_pulse !== 1'b1) $display("FAIL rot_busy_during_pulse: got %b want 1", busy_at_pulse); else n_pass++;
    n_total++; if (ng != 2) $display("FAIL rot_grant_count: got %0d want 2", ng); else n_pass++;
    if (ng >= 2) begin
      n_total++; if (gseq[0] !== 4'b1000) $display("FAIL rot_first: got %b want 1000", gseq[0]); else n_pass++;
      n_total++; if (gseq[1] !== 4'b0001) $display("FAIL rot_second: got %b want 0001", gseq[1]); else n_pass++;
    end
    n_total++; if (saw1) $display("FAIL busy_pulse_granted: got 1 want 0"); else n_pass++;
  endtask

  task automatic test_data_stability();
    logic p; logic [1:0] did; int lat;
    lat = -1; p = 1'bx; did = 2'bxx;
    @(negedge clk);
    set_word(0, 1, 32'h0000_0001);
    if0.req = 4'b0010;
    @(negedge clk);
    n_total++; if (if0.gnt !== 4'b0010) $display("FAIL stab_gnt: got %b want 0010", if0.gnt); else n_pass++;
    if0.req = 4'b0;
    @(negedge clk);
    set_word(0, 1, 32'h0100_0001);
    for (int k = 2; k <= 10; k++) begin
      if (if0.done === 1'b1) begin
        lat = k; p = if0.parity_out; did = if0.done_id;
        break;
      end
      @(negedge clk);
    end
    n_total++; if (lat != 5) $display("FAIL stab_latency: got %0d want 5", lat); else n_pass++;
    n_total++; if (p !== 1'b1) $display("FAIL stab_parity: got %b want 1", p); else n_pass++;
    n_total++; if (did !== 2'd1) $display("FAIL stab_id: got %0d want 1", did); else n_pass++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int ndone;
    ndone = 0;
    @(negedge clk);
    set_word(0, 2, 32'h0000_0001);
    if0.req = 4'b0100;
    @(negedge clk);
    if0.req = 4'b0;
    n_total++; if (if0.busy !== 1'b1) $display("FAIL rmid_busy_before: got %b want 1", if0.busy); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_total++; if (if0.busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", if0.busy); else n_pass++;
    n_total++; if (if0.done !== 1'b0) $display("FAIL rmid_done: got %b want 0", if0.done); else n_pass++;
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if0.done === 1'b1) ndone++;
    end
    n_total++; if (ndone != 0) $display("FAIL rmid_no_done: got %0d want 0", ndone); else n_pass++;
    if0.req = 4'b1111;
    @(negedge clk);
    n_total++; if (if0.gnt !== 4'b0001) $display("FAIL rmid_next_gnt: got %b want 0001", if0.gnt); else n_pass++;
    if0.req = 4'b0;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity_words();
    test_fairness();
    test_rotation();
    test_data_stability();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
